cpu_controller: RTL and testbench

Eight-phase instruction sequencer for the 8-bit CPU. It takes the 3-bit opcode held in the instruction register and the zero flag from the ALU (`SKZ_cmp`). Each cycle it drives the control strobes that steer the address mux, memory, instruction register, program counter and accumulator. It sits directly upstream of the ALU: the opcode it decodes is the same one routed to `ALU_OP`, and it consumes `SKZ_cmp` for skip decisions.

---
 rtl/cpu_controller.sv | 127 ++++++++++++
 tb/tb_cpu_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit CPU.
// Steps fetch/execute phases and decodes control strobes per opcode.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OPC_HLT = 3'b000;
  localparam logic [2:0] OPC_SKZ = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_AND = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_LDA = 3'b101;
  localparam logic [2:0] OPC_STO = 3'b110;
  localparam logic [2:0] OPC_JMP = 3'b111;

  phase_t ph;
  logic   halted;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic is_alu;

  assign is_hlt = (opcode == OPC_HLT);
  assign is_skz = (opcode == OPC_SKZ);
  assign is_sto = (opcode == OPC_STO);
  assign is_jmp = (opcode == OPC_JMP);
  assign is_alu = (opcode == OPC_ADD) ||
                  (opcode == OPC_AND) ||
                  (opcode == OPC_XOR) ||
                  (opcode == OPC_LDA);

  // Once halted, the counter parks at OP_ADDR until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (ph == OP_ADDR && is_hlt) begin
        halted <= 1'b1;
      end else begin
        ph <= phase_t'(ph + 3'd1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (ph)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = is_alu;
        end
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz & zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          // PC block resolves ld_pc over inc_pc for JMP.
          rd     = is_alu;
          ld_ac  = is_alu;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = ph;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller.
// Stimulus pushes hand-computed vectors; monitor checks at negedge.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc;
  logic       ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] ph;
    logic [8:0] outs;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic stim_done = 1'b0;

  // outs order: halt sel rd ld_ir inc_pc ld_pc ld_ac wr data_e
  localparam logic [8:0] V_P0   = 9'h080;
  localparam logic [8:0] V_P1   = 9'h0C0;
  localparam logic [8:0] V_P23  = 9'h0E0;
  localparam logic [8:0] V_INC  = 9'h010;
  localparam logic [8:0] V_NONE = 9'h000;
  localparam logic [8:0] V_RD   = 9'h040;
  localparam logic [8:0] V_RDAC = 9'h044;
  localparam logic [8:0] V_DE   = 9'h001;
  localparam logic [8:0] V_WRDE = 9'h003;
  localparam logic [8:0] V_LDPC = 9'h008;
  localparam logic [8:0] V_JMP7 = 9'h018;
  localparam logic [8:0] V_HLT4 = 9'h110;
  localparam logic [8:0] V_HLTD = 9'h100;

  localparam logic [35:0] FETCH = {V_P0, V_P1, V_P23, V_P23};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {halt, sel, rd, ld_ir, inc_pc,
             ld_pc, ld_ac, wr, data_e};
      n_total++;
      if (phase === e.ph && act === e.outs) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got phase=%0d outs=%09b, want phase=%0d outs=%09b",
                 e.name, phase, act, e.ph, e.outs);
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] p,
                      input logic [8:0] o);
    exp_t e;
    e.name = nm;
    e.ph   = p;
    e.outs = o;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [2:0] p,
                      input logic [8:0] o);
    push(nm, p, o);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [2:0] op,
                           input logic z, input logic [71:0] tbl);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      step($sformatf("%s_p%0d", nm, p), 3'(p),
           tbl[(7 - p) * 9 +: 9]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    opcode = 3'b010;
    zero   = 1'b0;
    push("reset", 3'd0, V_P0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Run to phase 5, then reset between edges.
    for (int p = 0; p < 5; p++) begin
      step($sformatf("pre_rst_p%0d", p), 3'(p),
           FETCH >> 0 == 0 ? V_NONE : (p < 4 ?
           FETCH[(3 - p) * 9 +: 9] : V_INC));
    end
    push("pre_rst_p5", 3'd5, V_RD);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push("mid_rst", 3'd0, V_P0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      step($sformatf("post_rst_%0d", i), 3'(i % 8),
           (i % 8) == 0 ? V_P0 :
           (i == 1) ? V_P1 :
           (i < 4) ? V_P23 :
           (i == 4) ? V_INC :
           (i == 7) ? V_RDAC : V_RD);
    end
    // Phase now 1; finish this ADD instruction.
    for (int p = 1; p < 8; p++) begin
      step($sformatf("add_tail_p%0d", p), 3'(p),
           p < 4 ? FETCH[(3 - p) * 9 +: 9] :
           p == 4 ? V_INC : p == 7 ? V_RDAC : V_RD);
    end

    run_instr("add", 3'b010, 1'b0,
              {FETCH, V_INC, V_RD, V_RD, V_RDAC});
    run_instr("lda", 3'b101, 1'b1,
              {FETCH, V_INC, V_RD, V_RD, V_RDAC});
    run_instr("skz_z1", 3'b001, 1'b1,
              {FETCH, V_INC, V_NONE, V_INC, V_NONE});
    run_instr("skz_z0", 3'b001, 1'b0,
              {FETCH, V_INC, V_NONE, V_NONE, V_NONE});
    run_instr("sto", 3'b110, 1'b1,
              {FETCH, V_INC, V_NONE, V_DE, V_WRDE});
    run_instr("jmp", 3'b111, 1'b0,
              {FETCH, V_INC, V_NONE, V_LDPC, V_JMP7});

    opcode = 3'b000;
    zero   = 1'b1;
    for (int p = 0; p < 4; p++) begin
      step($sformatf("hlt_p%0d", p), 3'(p), FETCH[(3 - p) * 9 +: 9]);
    end
    step("hlt_p4", 3'd4, V_HLT4);
    for (int i = 0; i < 22; i++) begin
      if (i == 10) opcode = 3'b111;
      step($sformatf("halted_%0d", i), 3'd4, V_HLTD);
    end

    rst = 1'b1;
    #1;
    push("hlt_rst", 3'd0, V_P0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    opcode = 3'b010;
    @(posedge clk);
    #1;
    step("after_hlt_rst", 3'd1, V_P1);

    @(negedge clk);
    #1;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
